// File: rtl/contar_vecinos.sv
`default_nettype none
// ============================================================================
// Module      : contar_vecinos
// Description : Writes into every non-bomb cell of an N x N board the number
//               of bombs next to it. One cell is processed per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module contar_vecinos #(
    parameter int          N    = 8,
    parameter logic [3:0]  BOMB = 4'hF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [N-1:0][N-1:0][3:0]  matriz_in,
    output logic [N-1:0][N-1:0][3:0]  matriz_out,
    output logic                      busy,
    output logic                      done,
    output logic                      valid
);

    localparam int              c_PW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_PW-1:0] c_LAST = c_PW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    logic [N-1:0][N-1:0][3:0]   r_board;
    logic [c_PW-1:0]            r_pos_x;
    logic [c_PW-1:0]            r_pos_y;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_valid;
    logic [3:0]                 w_count;

    assign matriz_out = r_board;
    assign busy       = r_busy;
    assign done       = r_done;
    assign valid      = r_valid;

    // Neighbours off the board count as empty; the board never wraps around.
    always_comb begin
        int nx;
        int ny;
        w_count = 4'd0;
        nx      = 0;
        ny      = 0;
        for (int dx = -1; dx <= 1; dx++) begin
            for (int dy = -1; dy <= 1; dy++) begin
                nx = int'(r_pos_x) + dx;
                ny = int'(r_pos_y) + dy;
                if (!(dx == 0 && dy == 0) && nx >= 0 && nx < N && ny >= 0 && ny < N) begin
                    if (r_board[nx[c_PW-1:0]][ny[c_PW-1:0]] == BOMB) begin
                        w_count = w_count + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_board <= '0;
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_board <= matriz_in;
                        r_pos_x <= '0;
                        r_pos_y <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // In-place update is safe: counts written so far never equal BOMB.
                    if (r_board[r_pos_x][r_pos_y] != BOMB) begin
                        r_board[r_pos_x][r_pos_y] <= w_count;
                    end
                    if (r_pos_x == c_LAST) begin
                        r_pos_x <= '0;
                        if (r_pos_y == c_LAST) begin
                            r_pos_y <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_pos_y <= r_pos_y + 1'b1;
                        end
                    end else begin
                        r_pos_x <= r_pos_x + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_contar_vecinos.sv
`default_nettype none
// ============================================================================
// Module      : tb_contar_vecinos
// Description : Directed bench for contar_vecinos with a board scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contar_vecinos;

    typedef logic [7:0][7:0][3:0] board_t;

    logic   clock;
    logic   reset;
    logic   start;
    board_t matriz_in;
    board_t matriz_out;
    logic   busy;
    logic   done;
    logic   valid;

    int     tests;
    int     fails;
    board_t sb[$];

    contar_vecinos #(.N(8), .BOMB(4'hF)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .matriz_in  (matriz_in),
        .matriz_out (matriz_out),
        .busy       (busy),
        .done       (done),
        .valid      (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference counts are taken from the untouched input board.
    function automatic board_t model(input board_t b);
        board_t r;
        int     cnt;
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                if (b[x][y] == 4'hF) begin
                    r[x][y] = 4'hF;
                end else begin
                    cnt = 0;
                    for (int dx = -1; dx <= 1; dx++)
                        for (int dy = -1; dy <= 1; dy++)
                            if ((dx != 0 || dy != 0) && x+dx >= 0 && x+dx < 8 && y+dy >= 0 && y+dy < 8)
                                if (b[x+dx][y+dy] == 4'hF) cnt++;
                    r[x][y] = 4'(cnt);
                end
            end
        end
        return r;
    endfunction

    task automatic run_board(input board_t b, input string tag, input bit mid);
        int     edges;
        bit     seen;
        board_t exp;
        matriz_in = b;
        start     = 1'b1;
        sb.push_back(model(b));
        tick();
        start = 1'b0;
        chk({tag, "_busy_on_start"}, 256'(busy), 256'(1));
        chk({tag, "_valid_cleared"}, 256'(valid), 256'(0));
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 100) begin
            if (mid && edges == 10) begin
                start     = 1'b1;
                matriz_in = ~b;
            end
            if (mid && edges == 13) start = 1'b0;
            tick();
            edges++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_latency"}, 256'(edges), 256'(64));
        exp = sb.pop_front();
        if (seen) begin
            chk({tag, "_busy_in_done"}, 256'(busy), 256'(0));
            chk({tag, "_valid_in_done"}, 256'(valid), 256'(1));
            chk({tag, "_board"}, 256'(matriz_out), 256'(exp));
            if (mid) start = 1'b1;
            tick();
            start = 1'b0;
            chk({tag, "_done_cleared"}, 256'(done), 256'(0));
            chk({tag, "_valid_held"}, 256'(valid), 256'(1));
            chk({tag, "_idle_not_busy"}, 256'(busy), 256'(0));
            if (mid) begin
                for (int i = 0; i < 3; i++) begin
                    tick();
                    chk({tag, "_single_done"}, 256'({done, busy}), 256'(0));
                end
            end
        end
    endtask

    initial begin
        board_t b;
        tests     = 0;
        fails     = 0;
        reset     = 1'b0;
        start     = 1'b0;
        matriz_in = '0;
        tick();
        tick();
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_valid", 256'(valid), 256'(0));
        chk("rst_board", 256'(matriz_out), 256'(0));
        reset = 1'b1;
        tick();

        b = '0;
        run_board(b, "empty", 1'b0);
        chk("empty_all_zero", 256'(matriz_out), 256'(0));
        matriz_in = '1;
        tick();
        tick();
        chk("idle_hold_board", 256'(matriz_out), 256'(0));
        chk("idle_hold_valid", 256'(valid), 256'(1));

        b = '0;
        b[3][3] = 4'hF;
        run_board(b, "bomb33", 1'b0);
        chk("bomb33_center", 256'(matriz_out[3][3]), 256'(4'hF));
        chk("bomb33_nb22", 256'(matriz_out[2][2]), 256'(1));
        chk("bomb33_nb43", 256'(matriz_out[4][3]), 256'(1));
        chk("bomb33_far55", 256'(matriz_out[5][5]), 256'(0));

        b = '0;
        b[0][0] = 4'hF;
        run_board(b, "corner", 1'b0);
        chk("corner_10", 256'(matriz_out[1][0]), 256'(1));
        chk("corner_01", 256'(matriz_out[0][1]), 256'(1));
        chk("corner_11", 256'(matriz_out[1][1]), 256'(1));
        chk("corner_77", 256'(matriz_out[7][7]), 256'(0));
        chk("corner_70", 256'(matriz_out[7][0]), 256'(0));
        chk("corner_07", 256'(matriz_out[0][7]), 256'(0));

        b = '1;
        b[4][4] = 4'h3;
        run_board(b, "full", 1'b0);
        chk("full_44", 256'(matriz_out[4][4]), 256'(8));
        chk("full_33", 256'(matriz_out[3][3]), 256'(4'hF));

        b = '0;
        b[0][0] = 4'hF;
        b[2][0] = 4'hF;
        b[1][0] = 4'h5;
        run_board(b, "pair", 1'b0);
        chk("pair_10", 256'(matriz_out[1][0]), 256'(2));
        chk("pair_11", 256'(matriz_out[1][1]), 256'(2));

        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                b[x][y] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        run_board(b, "random", 1'b0);

        b = '0;
        b[6][1] = 4'hF;
        b[7][2] = 4'hF;
        run_board(b, "midstart", 1'b1);

        matriz_in = '1;
        matriz_in[5][5] = 4'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        reset = 1'b0;
        #1;
        chk("abort_busy", 256'(busy), 256'(0));
        chk("abort_done", 256'(done), 256'(0));
        chk("abort_valid", 256'(valid), 256'(0));
        chk("abort_board", 256'(matriz_out), 256'(0));
        #4;
        reset = 1'b1;
        tick();

        b = '0;
        b[7][7] = 4'hF;
        b[5][6] = 4'hF;
        run_board(b, "after_reset", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
